mips_mc_datapath: RTL and testbench
===================================

// Module: mips_mc_datapath
// PURPOSE
//  Multi-cycle, parametrised successor of the single-cycle MIPS datapath. It sits between the control unit and the ALU/memory.
//  It accepts one instruction plus its control bundle per valid/ready handshake, then steps it through DECODE/EXEC/MEM/WB.
//  It adds data-memory wait states, alignment and range checks, an overflow flag and a done pulse.
// PARAMETERS
//  DATA_W      32  datapath width; legal values 16/32/64; imm sign-extended to DATA_W
//  DMEM_WORDS  64  data memory depth in DATA_W words (power of 2)
//  MEM_LAT     2   cycles spent in MEM state per load/store (>=1)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       synchronous active-low reset
//  I            in   32      instruction: rs=I[25:21] rt=I[20:16] rd=I[15:11] imm=I[15:0]
//  opcode       in   3       ALU op (see BEHAVIOUR)
//  RegW,Regdst,MemR,MemW,MemtoReg,ALUSrc  in 1 each  control bundle, sampled with I
//  instr_valid  in   1       I/opcode/controls valid
//  instr_ready  out  1       high only in IDLE; accept = valid & ready
//  busy         out  1       state != IDLE
//  done         out  1       one-cycle pulse in WB
//  alu_result   out  DATA_W  latched ALU output
//  reg1,reg2    out  DATA_W  latched rs/rt read data
//  ReadData     out  DATA_W  latched memory read data (0 if no load)
//  out          out  DATA_W  write-back value (MemtoReg ? ReadData : alu_result)
//  overflow     out  1       signed overflow of op 010/110, held until next accept
//  addr_err     out  1       misaligned or out-of-range memory access, held until next accept
// BEHAVIOUR
//  Reset: state=IDLE, every output 0 (instr_ready=1 after reset), reg[i]=i (i=0..31); dmem not reset.
//  States: IDLE -accept-> DECODE -> EXEC -> (MemR|MemW) ? MEM : WB; MEM -MEM_LAT cycles-> WB; WB -> IDLE.
//  Controls and I are captured on the accept edge; later input changes are ignored until IDLE.
//  DECODE: reg1=reg[rs], reg2=reg[rt]. EXEC: B = ALUSrc ? sext(imm) : reg2; alu_result latched.
//  ALU ops: 000 AND, 001 OR, 010 ADD (sets overflow), 011 XOR, 100 NOR, 101 ADD (address add, no flag),
//    110 SUB (sets overflow), 111 SLT (signed, result 0/1).
//  Address: byte address = alu_result. Word index = alu_result >> log2(DATA_W/8).
//    addr_err = low log2(DATA_W/8) bits != 0, or index >= DMEM_WORDS.
//  addr_err suppresses the store and forces ReadData=0. MEM is still traversed for the full MEM_LAT.
//  Store commits on the last MEM cycle: dmem[idx]=reg2. Load samples dmem on the last MEM cycle.
//  MemR&MemW together: the load returns the pre-store value and the store still commits.
//  WB: done=1. If RegW, then reg[Regdst?rd:rt] = out on the WB edge. Writes to reg0 are dropped; reg0 always reads 0.
//  Latency from accept edge to done: 3 cycles without memory, 3+MEM_LAT cycles with memory.
//  Next accept is possible the cycle after done.
//  instr_valid while busy: ignored, not queued. The source must hold valid until ready.
//  Reset mid-operation: returns to IDLE next edge. No register write; a store is lost unless it already committed.
//  Outputs alu_result/reg1/reg2/ReadData/out/flags hold their values from done until the next accept.
// STRUCTURE
//  mips_dp_pkg: ALU opcode localparams, state enum (IDLE/DECODE/EXEC/MEM/WB), instruction field bit positions.
//  Sub-module mips_regfile: 32 x DATA_W, 2 async read ports, 1 sync write port. Reset-to-index; reg0 hardwired 0.
//  Top level: FSM, MEM_LAT counter, ALU, sign-extend, address check, dmem array.
// TESTING (DATA_W=32, MEM_LAT=2)
//  1 reset: after rst_n low 2 cycles -> instr_ready=1, outputs 0, a read of rs=7 returns reg1=7.
//  2 SW rs=4 rt=5 imm=8, op 101, MemW, ALUSrc
//    -> alu_result=12, dmem[3]=5, done 5 cycles after accept, addr_err=0.
//  3 LW rs=0 rt=9 imm=12, op 101, MemR, MemtoReg, RegW, ALUSrc
//    -> ReadData=5, out=5, reg9=5.
//  4 R-type rs=3 rt=7 rd=10, op 110, Regdst, RegW
//    -> reg10=0xFFFFFFFC, done 3 cycles after accept. Then op 111 with same regs -> reg10=1.
//  5 I=rs2,rt1,imm0, op 101, MemW, ALUSrc, MemtoReg, RegW=1, Regdst=0
//    -> alu_result=2, addr_err=1, no store, ReadData=0, reg1=2 after WB.
//    Then imm=0x100 -> index 64 -> addr_err=1.
//  6 rst_n low in the first MEM cycle of test 2 with dmem[3] preset to 0
//    -> IDLE next edge, dmem[3] stays 0, no done. Also hold instr_valid high while busy -> exactly one accept per done.

Source files
------------

// File: rtl/mips_dp_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath: ALU opcodes,
// FSM state encoding, instruction field positions and the control bundle.
package mips_dp_pkg;

  // ALU operation codes
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;  // arithmetic add, sets overflow
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_ADDA = 3'b101;  // address add, never flags
  localparam logic [2:0] OP_SUB  = 3'b110;  // arithmetic sub, sets overflow
  localparam logic [2:0] OP_SLT  = 3'b111;  // signed set-less-than

  // Instruction field positions
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int REG_AW = 5;
  localparam int IMM_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Control bundle captured together with the instruction
  typedef struct packed {
    logic reg_w;
    logic reg_dst;
    logic mem_r;
    logic mem_w;
    logic mem_to_reg;
    logic alu_src;
  } ctrl_t;

endpackage

// File: rtl/mips_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous
// write port. Reset loads each register with its own index; register 0
// always reads zero and ignores writes.
module mips_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs [32];

  // Reset-to-index, then single write port; writes to register 0 are dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= DATA_W'(i);
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  // Asynchronous reads with register 0 hardwired to zero
  always_comb begin
    rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
  end

endmodule

// File: rtl/mips_mc_datapath.sv
// Multi-cycle MIPS datapath. Accepts one instruction plus control bundle
// per valid/ready handshake and walks it through DECODE, EXEC, optional
// MEM (MEM_LAT cycles) and WB, pulsing done in WB.
//
// Handshake: an instruction is accepted on a rising edge where
// instr_valid && instr_ready; instr_ready is high only in IDLE, so
// valid asserted while busy is simply ignored (nothing is queued) and
// the source must keep valid high until it sees ready.
module mips_mc_datapath
  import mips_dp_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DMEM_WORDS = 64,
  parameter int MEM_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       I,
  input  logic [2:0]        opcode,
  input  logic              RegW,
  input  logic              Regdst,
  input  logic              MemR,
  input  logic              MemW,
  input  logic              MemtoReg,
  input  logic              ALUSrc,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] ReadData,
  output logic [DATA_W-1:0] out,
  output logic              overflow,
  output logic              addr_err,
  output state_t            state_dbg
);

  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int IDX_W   = $clog2(DMEM_WORDS);
  localparam int CNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [DATA_W-1:0] DMEM_LIMIT = DATA_W'(DMEM_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(MEM_LAT - 1);

  state_t            state;
  logic [25:0]       ir;
  ctrl_t             ctrl_q;
  logic [2:0]        op_q;
  logic [CNT_W-1:0]  mem_cnt;

  logic [DATA_W-1:0] dmem [DMEM_WORDS];

  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic [4:0]        rs, rt, rd, wa;
  logic [DATA_W-1:0] imm_ext, b_op, add_sum, sub_diff, alu_c, load_val;
  logic              add_ovf, sub_ovf, mem_last, is_mem, rf_we;
  logic [IDX_W-1:0]  dmem_idx;
  logic              unused_opfield;

  // The primary opcode field is decoded by the control unit, not here
  assign unused_opfield = ^I[31:26];

  assign rs = ir[RS_LSB +: REG_AW];
  assign rt = ir[RT_LSB +: REG_AW];
  assign rd = ir[RD_LSB +: REG_AW];
  assign wa = ctrl_q.reg_dst ? rd : rt;
  assign rf_we = (state == S_WB) && ctrl_q.reg_w;
  assign is_mem = ctrl_q.mem_r || ctrl_q.mem_w;
  assign mem_last = (mem_cnt == CNT_LAST);
  assign dmem_idx = alu_result[BYTE_SH +: IDX_W];
  assign state_dbg = state;

  // Misaligned byte address or word index beyond the memory depth
  function automatic logic addr_bad(input logic [DATA_W-1:0] a);
    addr_bad = (a[BYTE_SH-1:0] != '0) || ((a >> BYTE_SH) >= DMEM_LIMIT);
  endfunction

  mips_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk  (clk),
    .rst_n(rst_n),
    .ra1  (rs),
    .ra2  (rt),
    .we   (rf_we),
    .wa   (wa),
    .wd   (out),
    .rd1  (rf_rd1),
    .rd2  (rf_rd2)
  );

  // ALU on the latched operands, with signed-overflow detection for ADD/SUB
  always_comb begin
    imm_ext  = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    b_op     = ctrl_q.alu_src ? imm_ext : reg2;
    add_sum  = reg1 + b_op;
    sub_diff = reg1 - b_op;
    add_ovf  = (reg1[DATA_W-1] == b_op[DATA_W-1]) && (add_sum[DATA_W-1] != reg1[DATA_W-1]);
    sub_ovf  = (reg1[DATA_W-1] != b_op[DATA_W-1]) && (sub_diff[DATA_W-1] != reg1[DATA_W-1]);
    alu_c    = '0;
    case (op_q)
      OP_AND:  alu_c = reg1 & b_op;
      OP_OR:   alu_c = reg1 | b_op;
      OP_ADD:  alu_c = add_sum;
      OP_XOR:  alu_c = reg1 ^ b_op;
      OP_NOR:  alu_c = ~(reg1 | b_op);
      OP_ADDA: alu_c = add_sum;
      OP_SUB:  alu_c = sub_diff;
      OP_SLT:  alu_c = {{(DATA_W-1){1'b0}}, ($signed(reg1) < $signed(b_op))};
      default: alu_c = '0;
    endcase
  end

  // Load data seen on the last MEM cycle; a bad address reads as zero
  always_comb begin
    load_val = '0;
    if (ctrl_q.mem_r && !addr_err) load_val = dmem[dmem_idx];
  end

  // Data memory store, committed only on the last MEM cycle of a good access
  always_ff @(posedge clk) begin
    if (rst_n && (state == S_MEM) && mem_last && ctrl_q.mem_w && !addr_err) begin
      dmem[dmem_idx] <= reg2;
    end
  end

  // Main FSM with registered handshake, status and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ir          <= '0;
      ctrl_q      <= '0;
      op_q        <= '0;
      mem_cnt     <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      alu_result  <= '0;
      reg1        <= '0;
      reg2        <= '0;
      ReadData    <= '0;
      out         <= '0;
      overflow    <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            ir          <= I[25:0];
            ctrl_q      <= '{reg_w: RegW, reg_dst: Regdst, mem_r: MemR, mem_w: MemW,
                             mem_to_reg: MemtoReg, alu_src: ALUSrc};
            op_q        <= opcode;
            ReadData    <= '0;
            overflow    <= 1'b0;
            addr_err    <= 1'b0;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          reg1  <= rf_rd1;
          reg2  <= rf_rd2;
          state <= S_EXEC;
        end
        S_EXEC: begin
          alu_result <= alu_c;
          overflow   <= ((op_q == OP_ADD) && add_ovf) || ((op_q == OP_SUB) && sub_ovf);
          mem_cnt    <= '0;
          if (is_mem) begin
            addr_err <= addr_bad(alu_c);
            state    <= S_MEM;
          end else begin
            // No load happened, so ReadData stays zero
            out   <= ctrl_q.mem_to_reg ? '0 : alu_c;
            done  <= 1'b1;
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_last) begin
            ReadData <= load_val;
            out      <= ctrl_q.mem_to_reg ? load_val : alu_result;
            done     <= 1'b1;
            state    <= S_WB;
          end else begin
            mem_cnt <= mem_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_datapath.sv
// Directed bench for mips_mc_datapath (DATA_W=32, DMEM_WORDS=64, MEM_LAT=2).
module tb_mips_mc_datapath;
  import mips_dp_pkg::*;

  localparam logic [5:0] C_REGW  = 6'b100000;
  localparam logic [5:0] C_RDST  = 6'b010000;
  localparam logic [5:0] C_MEMR  = 6'b001000;
  localparam logic [5:0] C_MEMW  = 6'b000100;
  localparam logic [5:0] C_M2R   = 6'b000010;
  localparam logic [5:0] C_ALUS  = 6'b000001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] I;
  logic [2:0]  opcode;
  logic        RegW, Regdst, MemR, MemW, MemtoReg, ALUSrc;
  logic        instr_valid;
  logic        instr_ready, busy, done, overflow, addr_err;
  logic [31:0] alu_result, reg1, reg2, ReadData, out;
  state_t      state_dbg;

  int checks = 0;
  int errors = 0;
  int lat;

  mips_mc_datapath #(.DATA_W(32), .DMEM_WORDS(64), .MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .I(I), .opcode(opcode),
    .RegW(RegW), .Regdst(Regdst), .MemR(MemR), .MemW(MemW),
    .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .busy(busy), .done(done),
    .alu_result(alu_result), .reg1(reg1), .reg2(reg2), .ReadData(ReadData),
    .out(out), .overflow(overflow), .addr_err(addr_err), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    mk_r = {6'b0, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    mk_i = {6'b0, rs, rt, imm};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [2:0] op, input logic [5:0] c);
    I = instr;
    opcode = op;
    {RegW, Regdst, MemR, MemW, MemtoReg, ALUSrc} = c;
  endtask

  // Wait for ready at a negedge (bounded), then present valid for one cycle
  task automatic present(input logic [31:0] instr, input logic [2:0] op, input logic [5:0] c);
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 64'd0, 64'd1);
    drive(instr, op, c);
    instr_valid = 1'b1;
  endtask

  // Issue one instruction; lat = cycles from accept cycle (0) to the done cycle
  task automatic issue(input logic [31:0] instr, input logic [2:0] op, input logic [5:0] c,
                       output int l);
    present(instr, op, c);
    @(negedge clk);
    instr_valid = 1'b0;
    // scramble inputs after accept: they must be ignored
    drive($urandom, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)));
    l = 1;
    while (!done && l < 50) begin
      @(negedge clk);
      l++;
    end
    if (l >= 50) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic read_reg(input logic [4:0] r, input logic [31:0] exp, input string tag);
    int l;
    issue(mk_r(r, 5'd0, 5'd0), OP_OR, 6'b0, l);
    check(tag, reg1, exp);
  endtask

  initial begin
    int acc;
    int dn;
    logic [31:0] v;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    drive(32'h0, 3'b0, 6'b0);

    // 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_flags", {busy, done, overflow, addr_err}, 0);
    check("rst_data", alu_result | reg1 | reg2 | ReadData | out, 0);
    check("rst_state", state_dbg, S_IDLE);
    rst_n = 1'b1;
    issue(mk_r(5'd7, 5'd0, 5'd0), OP_OR, 6'b0, lat);
    check("rd7_reg1", reg1, 7);
    check("rd7_out", out, 7);
    check("rd7_lat", lat, 3);

    // 2: store word reg5 to byte address 4+8
    issue(mk_i(5'd4, 5'd5, 16'd8), OP_ADDA, C_MEMW | C_ALUS, lat);
    check("sw_alu", alu_result, 12);
    check("sw_lat", lat, 5);
    check("sw_aerr", addr_err, 0);
    check("sw_reg2", reg2, 5);
    check("sw_rdata", ReadData, 0);

    // 3: load word from address 12 into reg9
    issue(mk_i(5'd0, 5'd9, 16'd12), OP_ADDA, C_MEMR | C_M2R | C_REGW | C_ALUS, lat);
    check("lw_rdata", ReadData, 5);
    check("lw_out", out, 5);
    check("lw_lat", lat, 5);
    read_reg(5'd9, 32'd5, "lw_reg9");

    // 4: SUB and SLT into reg10
    issue(mk_r(5'd3, 5'd7, 5'd10), OP_SUB, C_RDST | C_REGW, lat);
    check("sub_out", out, 32'hFFFF_FFFC);
    check("sub_lat", lat, 3);
    check("sub_ovf", overflow, 0);
    read_reg(5'd10, 32'hFFFF_FFFC, "sub_reg10");
    issue(mk_r(5'd3, 5'd7, 5'd10), OP_SLT, C_RDST | C_REGW, lat);
    check("slt_out", out, 1);
    read_reg(5'd10, 32'd1, "slt_reg10");
    issue(mk_r(5'd3, 5'd7, 5'd12), OP_SUB, C_RDST | C_REGW, lat);
    issue(mk_r(5'd12, 5'd3, 5'd13), OP_SLT, C_RDST | C_REGW, lat);
    check("slt_signed", out, 1);
    issue(mk_r(5'd3, 5'd12, 5'd0), OP_SLT, 6'b0, lat);
    check("slt_false", out, 0);

    // logic ops on reg6=6, reg3=3
    issue(mk_r(5'd6, 5'd3, 5'd0), OP_AND, 6'b0, lat);
    check("and", alu_result, 2);
    issue(mk_r(5'd6, 5'd3, 5'd0), OP_XOR, 6'b0, lat);
    check("xor", alu_result, 5);
    issue(mk_r(5'd6, 5'd3, 5'd0), OP_NOR, 6'b0, lat);
    check("nor", alu_result, 32'hFFFF_FFF8);
    issue(mk_i(5'd6, 5'd0, 16'hFFFE), OP_ADD, C_ALUS, lat);
    check("addi_neg", alu_result, 4);

    // overflow: double 0x4000 until it crosses into the sign bit
    issue(mk_i(5'd0, 5'd11, 16'h4000), OP_ADD, C_REGW | C_ALUS, lat);
    check("ovf_seed", out, 32'h4000);
    for (int k = 1; k <= 16; k++) issue(mk_r(5'd11, 5'd11, 5'd11), OP_ADD, C_RDST | C_REGW, lat);
    check("dbl16_out", out, 32'h4000_0000);
    check("dbl16_ovf", overflow, 0);
    issue(mk_r(5'd11, 5'd11, 5'd11), OP_ADD, C_RDST | C_REGW, lat);
    check("dbl17_out", out, 32'h8000_0000);
    check("dbl17_ovf", overflow, 1);
    issue(mk_r(5'd11, 5'd1, 5'd14), OP_SUB, C_RDST | C_REGW, lat);
    check("subovf_out", out, 32'h7FFF_FFFF);
    check("subovf_ovf", overflow, 1);
    repeat (2) @(negedge clk);
    check("ovf_hold", overflow, 1);
    issue(mk_r(5'd11, 5'd11, 5'd0), OP_ADDA, 6'b0, lat);
    check("adda_out", alu_result, 0);
    check("adda_noflag", overflow, 0);

    // 5: misaligned store, MemtoReg writes zero back into reg1
    issue(mk_i(5'd2, 5'd1, 16'd0), OP_ADDA, C_MEMW | C_ALUS | C_M2R | C_REGW, lat);
    check("mis_alu", alu_result, 2);
    check("mis_aerr", addr_err, 1);
    check("mis_rdata", ReadData, 0);
    check("mis_reg1", reg1, 2);
    check("mis_lat", lat, 5);
    read_reg(5'd1, 32'd0, "mis_wb_reg1");
    issue(mk_i(5'd0, 5'd0, 16'h0100), OP_ADDA, C_MEMR | C_ALUS, lat);
    check("range_aerr", addr_err, 1);
    check("range_rdata", ReadData, 0);
    // last legal word, index 63
    issue(mk_i(5'd0, 5'd2, 16'h00FC), OP_ADDA, C_MEMW | C_ALUS, lat);
    check("top_aerr", addr_err, 0);
    issue(mk_i(5'd0, 5'd0, 16'h00FC), OP_ADDA, C_MEMR | C_ALUS, lat);
    check("top_rdata", ReadData, 2);
    // load+store together: load sees the old word, store still lands
    issue(mk_i(5'd0, 5'd3, 16'h00FC), OP_ADDA, C_MEMR | C_MEMW | C_ALUS, lat);
    check("rw_old", ReadData, 2);
    issue(mk_i(5'd0, 5'd0, 16'h00FC), OP_ADDA, C_MEMR | C_ALUS, lat);
    check("rw_new", ReadData, 3);

    // 6: reset in the first MEM cycle aborts the store
    issue(mk_i(5'd0, 5'd0, 16'd12), OP_ADDA, C_MEMW | C_ALUS, lat);
    present(mk_i(5'd4, 5'd5, 16'd8), OP_ADDA, C_MEMW | C_ALUS);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_in_mem", state_dbg, S_MEM);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_state", state_dbg, S_IDLE);
    check("abort_ready", instr_ready, 1);
    check("abort_busy", busy, 0);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("abort_nodone", dn, 0);
    issue(mk_i(5'd0, 5'd0, 16'd12), OP_ADDA, C_MEMR | C_ALUS, lat);
    check("abort_dmem3", ReadData, 0);
    read_reg(5'd9, 32'd9, "abort_reg9");

    // valid held high across busy periods: one accept per done
    present(mk_r(5'd7, 5'd0, 5'd0), OP_OR, 6'b0);
    acc = 0;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready) acc++;
      if (done) dn++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("hold_accepts", acc, 5);
    check("hold_dones", dn, 5);
    v = reg1;
    check("hold_reg1", v, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
